riscv_core_decode_stage: RTL and testbench

RISCV_CORE_DECODE_STAGE -- requirements
Module: riscv_core_decode_stage

---
 rtl/riscv_core_decode_stage_if.sv | 38 +++
 rtl/riscv_core_decode_stage.sv | 176 +++++++++++++++++
 tb/tb_riscv_core_decode_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_decode_stage_if.sv
// Handshake/data bundle between the decode stage and its neighbours.
// Ports: i_* are driven into the stage (fetch side plus downstream ready/flush),
//        o_* are driven by the stage (head entry, control bundle, illegal count).
interface riscv_core_decode_stage_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic             i_decode_stage_valid;
  logic             o_decode_stage_ready;
  logic [31:0]      i_decode_stage_instr;
  logic [XLEN-1:0]  i_decode_stage_pc;
  logic             i_decode_stage_flush;
  logic             o_decode_stage_valid;
  logic             i_decode_stage_ready;
  logic [31:0]      o_decode_stage_instr;
  logic [XLEN-1:0]  o_decode_stage_pc;
  logic [16:0]      o_decode_stage_ctrl;
  logic             o_decode_stage_illegal;
  logic [CNT_W-1:0] o_decode_stage_illegal_cnt;

  // Decode stage side.
  modport slave (
    input  i_decode_stage_valid, i_decode_stage_instr, i_decode_stage_pc,
    input  i_decode_stage_flush, i_decode_stage_ready,
    output o_decode_stage_ready, o_decode_stage_valid, o_decode_stage_instr,
    output o_decode_stage_pc, o_decode_stage_ctrl, o_decode_stage_illegal,
    output o_decode_stage_illegal_cnt
  );

  // Fetch / downstream side.
  modport master (
    output i_decode_stage_valid, i_decode_stage_instr, i_decode_stage_pc,
    output i_decode_stage_flush, i_decode_stage_ready,
    input  o_decode_stage_ready, o_decode_stage_valid, o_decode_stage_instr,
    input  o_decode_stage_pc, o_decode_stage_ctrl, o_decode_stage_illegal,
    input  o_decode_stage_illegal_cnt
  );
endinterface

// File: rtl/riscv_core_decode_stage.sv
// Purpose: RISC-V instruction decode into a 17-bit control bundle, buffered in a DEPTH-entry FIFO.
// Latency: 1 cycle (entry written on the accepting edge, visible right after it); no comb in->out path.
// Backpressure: ready while not full or while the head pops; flush empties the buffer and drops the push.
// Ports: i_decode_stage_clk / i_decode_stage_rst_n (async active-low), bus (slave modport):
//   valid/ready/instr/pc in, flush in, head valid/ready/instr/pc/ctrl/illegal out, saturating illegal count out.
module riscv_core_decode_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic                      i_decode_stage_clk,
  input logic                      i_decode_stage_rst_n,
  riscv_core_decode_stage_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("riscv_core_decode_stage: XLEN must be 32 or 64");
  end
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("riscv_core_decode_stage: DEPTH must be 1..4");
  end

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam bit RV32  = (XLEN == 32);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Field order: regwrite imsrc[2:0] uctrl alusrcb memwrite resultsrc[1:0]
  //              branch aluop size[1:0] ldext isword jump bjreg
  localparam logic [16:0] CTRL_OP     = 17'b1_000_0_0_0_00_0_1_00_0_0_0_0;
  localparam logic [16:0] CTRL_OPIMM  = 17'b1_000_0_1_0_00_0_1_00_0_0_0_0;
  localparam logic [16:0] CTRL_LOAD   = 17'b1_000_0_1_0_01_0_0_00_0_0_0_0;
  localparam logic [16:0] CTRL_STORE  = 17'b0_001_0_1_1_00_0_0_00_0_0_0_0;
  localparam logic [16:0] CTRL_BRANCH = 17'b0_010_0_1_0_00_1_0_00_0_0_0_0;
  localparam logic [16:0] CTRL_JAL    = 17'b1_011_0_1_0_10_0_0_00_0_0_1_0;
  localparam logic [16:0] CTRL_JALR   = 17'b1_000_0_1_0_10_0_0_00_0_0_1_1;
  localparam logic [16:0] CTRL_UPPER  = 17'b1_100_1_1_0_11_0_0_00_0_0_0_0;
  localparam logic [16:0] CTRL_ISWORD = 17'b0_000_0_0_0_00_0_0_00_0_1_0_0;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [16:0]     ctrl;
    logic            illegal;
  } entry_t;

  // ---------------- combinational decode ----------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [16:0] dec_ctrl;
  logic        dec_ill;

  always_comb begin
    opcode   = bus.i_decode_stage_instr[6:0];
    funct3   = bus.i_decode_stage_instr[14:12];
    dec_ctrl = '0;
    dec_ill  = 1'b0;
    case (opcode)
      OPC_OP:      dec_ctrl = CTRL_OP;
      OPC_OP32:    begin dec_ctrl = CTRL_OP | CTRL_ISWORD; dec_ill = RV32; end
      OPC_OPIMM:   dec_ctrl = CTRL_OPIMM;
      OPC_OPIMM32: begin dec_ctrl = CTRL_OPIMM | CTRL_ISWORD; dec_ill = RV32; end
      OPC_LOAD: begin
        // {size,ldext} is funct3 rotated: size = funct3[1:0], ldext = funct3[2]
        dec_ctrl = CTRL_LOAD | {11'b0, funct3[1:0], funct3[2], 3'b000};
        dec_ill  = (funct3 == 3'd7) || (RV32 && (funct3 == 3'd3 || funct3 == 3'd6));
      end
      OPC_STORE: begin
        dec_ctrl = CTRL_STORE | {11'b0, funct3[1:0], 4'b0000};
        dec_ill  = funct3[2] || (RV32 && funct3 == 3'd3);
      end
      OPC_BRANCH:          dec_ctrl = CTRL_BRANCH;
      OPC_JAL:             dec_ctrl = CTRL_JAL;
      OPC_JALR:            dec_ctrl = CTRL_JALR;
      OPC_LUI, OPC_AUIPC:  dec_ctrl = CTRL_UPPER;
      default:             dec_ill  = 1'b1;
    endcase
    if (bus.i_decode_stage_instr[1:0] != 2'b11) dec_ill = 1'b1;
    // Illegal entries must not carry any side-effecting control.
    if (dec_ill) dec_ctrl = '0;
  end

  // ---------------- output buffer ----------------
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_en_q, rdy_en_d;   // holds ready low until the first edge out of reset

  entry_t head;
  logic   out_vld;
  logic   full;
  logic   push;
  logic   pop;
  logic   in_rdy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head    = mem_q[rd_ptr_q];
  assign out_vld = (occ_q != '0);
  assign full    = (occ_q == OCC_W'(DEPTH));
  assign pop     = out_vld && bus.i_decode_stage_ready;
  assign in_rdy  = rdy_en_q && (!full || pop);
  assign push    = bus.i_decode_stage_valid && in_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    rdy_en_d = 1'b1;
    if (bus.i_decode_stage_flush) begin
      // Flush wins over push and pop; the head being discarded is not counted.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr:   bus.i_decode_stage_instr,
                            pc:      bus.i_decode_stage_pc,
                            ctrl:    dec_ctrl,
                            illegal: dec_ill};
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        if (head.illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      end
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge i_decode_stage_clk or negedge i_decode_stage_rst_n) begin
    if (!i_decode_stage_rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  // Head fields are gated by valid so an empty (or just-reset) buffer shows zeros.
  assign bus.o_decode_stage_ready       = in_rdy;
  assign bus.o_decode_stage_valid       = out_vld;
  assign bus.o_decode_stage_instr       = out_vld ? head.instr   : '0;
  assign bus.o_decode_stage_pc          = out_vld ? head.pc      : '0;
  assign bus.o_decode_stage_ctrl        = out_vld ? head.ctrl    : '0;
  assign bus.o_decode_stage_illegal     = out_vld ? head.illegal : 1'b0;
  assign bus.o_decode_stage_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_core_decode_stage.sv
module tb_riscv_core_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_core_decode_stage_if #(.XLEN(64), .CNT_W(16)) bus_a ();
  riscv_core_decode_stage_if #(.XLEN(32), .CNT_W(4))  bus_b ();

  riscv_core_decode_stage #(.XLEN(64), .DEPTH(2), .CNT_W(16)) dut_a (
    .i_decode_stage_clk   (clk),
    .i_decode_stage_rst_n (rst_n),
    .bus                  (bus_a)
  );

  riscv_core_decode_stage #(.XLEN(32), .DEPTH(3), .CNT_W(4)) dut_b (
    .i_decode_stage_clk   (clk),
    .i_decode_stage_rst_n (rst_n),
    .bus                  (bus_b)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [16:0] ctrl;
    logic        ill;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decode: {illegal, ctrl}
  function automatic logic [17:0] ref_dec(input logic [31:0] ins, input bit x32);
    logic [16:0] c;
    logic        ill;
    logic [2:0]  f3;
    f3  = ins[14:12];
    c   = '0;
    ill = 1'b0;
    case (ins[6:0])
      7'h33: c = 17'b1_000_0_0_0_00_0_1_00_0_0_0_0;
      7'h3B: begin c = 17'b1_000_0_0_0_00_0_1_00_0_1_0_0; ill = x32; end
      7'h13: c = 17'b1_000_0_1_0_00_0_1_00_0_0_0_0;
      7'h1B: begin c = 17'b1_000_0_1_0_00_0_1_00_0_1_0_0; ill = x32; end
      7'h03: begin
        case (f3)
          3'd0: c = 17'b1_000_0_1_0_01_0_0_00_0_0_0_0;
          3'd1: c = 17'b1_000_0_1_0_01_0_0_01_0_0_0_0;
          3'd2: c = 17'b1_000_0_1_0_01_0_0_10_0_0_0_0;
          3'd3: c = 17'b1_000_0_1_0_01_0_0_11_0_0_0_0;
          3'd4: c = 17'b1_000_0_1_0_01_0_0_00_1_0_0_0;
          3'd5: c = 17'b1_000_0_1_0_01_0_0_01_1_0_0_0;
          3'd6: c = 17'b1_000_0_1_0_01_0_0_10_1_0_0_0;
          default: ill = 1'b1;
        endcase
        if (x32 && (f3 == 3'd3 || f3 == 3'd6)) ill = 1'b1;
      end
      7'h23: begin
        if (f3 > 3'd3 || (x32 && f3 == 3'd3)) ill = 1'b1;
        else c = {11'b0_001_0_1_1_00_0_0, f3[1:0], 4'b0000};
      end
      7'h63: c = 17'b0_010_0_1_0_00_1_0_00_0_0_0_0;
      7'h6F: c = 17'b1_011_0_1_0_10_0_0_00_0_0_1_0;
      7'h67: c = 17'b1_000_0_1_0_10_0_0_00_0_0_1_1;
      7'h37, 7'h17: c = 17'b1_100_1_1_0_11_0_0_00_0_0_0_0;
      default: ill = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) ill = 1'b1;
    if (ill) c = '0;
    return {ill, c};
  endfunction

  function automatic exp_t mk(input logic [31:0] ins, input logic [63:0] pc, input bit x32);
    exp_t        e;
    logic [17:0] r;
    r       = ref_dec(ins, x32);
    e.instr = ins;
    e.pc    = pc;
    e.ctrl  = r[16:0];
    e.ill   = r[17];
    return e;
  endfunction

  // Scoreboard A: compare head on each pop, record pushes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qa.delete();
      cnt_a = '0;
    end else begin
      check("a_valid", bus_a.o_decode_stage_valid, qa.size() != 0);
      check("a_cnt", bus_a.o_decode_stage_illegal_cnt, cnt_a);
      if (bus_a.o_decode_stage_valid && bus_a.i_decode_stage_ready && !bus_a.i_decode_stage_flush) begin
        if (qa.size() == 0) check("a_spurious_pop", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_instr", bus_a.o_decode_stage_instr, e.instr);
          check("a_pc", bus_a.o_decode_stage_pc, e.pc);
          check("a_ctrl", bus_a.o_decode_stage_ctrl, e.ctrl);
          check("a_ill", bus_a.o_decode_stage_illegal, e.ill);
          if (e.ill && cnt_a != 16'hFFFF) cnt_a = cnt_a + 16'd1;
        end
      end
      if (bus_a.i_decode_stage_flush) qa.delete();
      else if (bus_a.i_decode_stage_valid && bus_a.o_decode_stage_ready)
        qa.push_back(mk(bus_a.i_decode_stage_instr, bus_a.i_decode_stage_pc, 1'b0));
    end
  end

  // Scoreboard B (XLEN=32, 4-bit counter).
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qb.delete();
      cnt_b = '0;
    end else begin
      check("b_valid", bus_b.o_decode_stage_valid, qb.size() != 0);
      check("b_cnt", bus_b.o_decode_stage_illegal_cnt, cnt_b);
      if (bus_b.o_decode_stage_valid && bus_b.i_decode_stage_ready && !bus_b.i_decode_stage_flush) begin
        if (qb.size() == 0) check("b_spurious_pop", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_instr", bus_b.o_decode_stage_instr, e.instr);
          check("b_pc", bus_b.o_decode_stage_pc, e.pc);
          check("b_ctrl", bus_b.o_decode_stage_ctrl, e.ctrl);
          check("b_ill", bus_b.o_decode_stage_illegal, e.ill);
          if (e.ill && cnt_b != 4'hF) cnt_b = cnt_b + 4'd1;
        end
      end
      if (bus_b.i_decode_stage_flush) qb.delete();
      else if (bus_b.i_decode_stage_valid && bus_b.o_decode_stage_ready)
        qb.push_back(mk(bus_b.i_decode_stage_instr, {32'b0, bus_b.i_decode_stage_pc}, 1'b1));
    end
  end

  // Entered and left at posedge+1; holds valid until the stage accepts.
  task automatic push(input bit sel, input logic [31:0] ins, input logic [63:0] pc, input bit rnd);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    if (sel) begin
      bus_b.i_decode_stage_instr = ins;
      bus_b.i_decode_stage_pc    = pc[31:0];
      bus_b.i_decode_stage_valid = 1'b1;
    end else begin
      bus_a.i_decode_stage_instr = ins;
      bus_a.i_decode_stage_pc    = pc;
      bus_a.i_decode_stage_valid = 1'b1;
    end
    while (!done) begin
      if (rnd) begin
        if (sel) bus_b.i_decode_stage_ready = 1'($urandom_range(0, 1));
        else     bus_a.i_decode_stage_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      done = sel ? bus_b.o_decode_stage_ready : bus_a.o_decode_stage_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        if (sel) check("b_push_timeout", 0, 1);
        else     check("a_push_timeout", 0, 1);
        done = 1'b1;
      end
    end
    if (sel) bus_b.i_decode_stage_valid = 1'b0;
    else     bus_a.i_decode_stage_valid = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int n;
    n = 0;
    if (sel) bus_b.i_decode_stage_ready = 1'b1;
    else     bus_a.i_decode_stage_ready = 1'b1;
    while ((sel ? qb.size() : qa.size()) != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      if (sel) check("b_drain_timeout", 0, 1);
      else     check("a_drain_timeout", 0, 1);
    end
  endtask

  logic [31:0] stream[$];

  initial begin
    rst_n = 1'b0;
    bus_a.i_decode_stage_valid = 1'b0; bus_a.i_decode_stage_instr = '0; bus_a.i_decode_stage_pc = '0;
    bus_a.i_decode_stage_flush = 1'b0; bus_a.i_decode_stage_ready = 1'b0;
    bus_b.i_decode_stage_valid = 1'b0; bus_b.i_decode_stage_instr = '0; bus_b.i_decode_stage_pc = '0;
    bus_b.i_decode_stage_flush = 1'b0; bus_b.i_decode_stage_ready = 1'b0;

    stream = '{32'h00B50533, 32'h00B5053B, 32'h00150513, 32'h0015051B,
               32'h00B50463, 32'h008000EF, 32'h000080E7, 32'h123452B7, 32'h00001297,
               32'h0000007F, 32'h00000010, 32'hFFFFFFFF, 32'h0000000B};
    for (int f = 0; f < 8; f++) begin
      stream.push_back(32'h00050003 | (32'(f) << 12));
      stream.push_back(32'h00A50023 | (32'(f) << 12));
    end

    // Reset values
    #12;
    check("rst_a_valid", bus_a.o_decode_stage_valid, 0);
    check("rst_a_ready", bus_a.o_decode_stage_ready, 0);
    check("rst_a_ctrl", bus_a.o_decode_stage_ctrl, 0);
    check("rst_a_instr", bus_a.o_decode_stage_instr, 0);
    check("rst_a_pc", bus_a.o_decode_stage_pc, 0);
    check("rst_a_cnt", bus_a.o_decode_stage_illegal_cnt, 0);
    check("rst_b_ready", bus_b.o_decode_stage_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("a_ready_after_rst", bus_a.o_decode_stage_ready, 1);
    check("b_ready_after_rst", bus_b.o_decode_stage_ready, 1);

    // addi, one-cycle latency
    bus_a.i_decode_stage_ready = 1'b1;
    push(1'b0, 32'h00A00093, 64'h1000, 1'b0);
    check("addi_valid", bus_a.o_decode_stage_valid, 1);
    check("addi_ctrl", bus_a.o_decode_stage_ctrl, 17'b1_000_0_1_0_00_0_1_00_0_0_0_0);
    check("addi_ill", bus_a.o_decode_stage_illegal, 0);
    drain(1'b0);

    // ld on RV64
    bus_a.i_decode_stage_ready = 1'b0;
    push(1'b0, 32'h0000B103, 64'h1004, 1'b0);
    check("ld64_ctrl", bus_a.o_decode_stage_ctrl, 17'b1_000_0_1_0_01_0_0_11_0_0_0_0);
    check("ld64_ill", bus_a.o_decode_stage_illegal, 0);
    drain(1'b0);

    // Mixed stream with random downstream stalls
    foreach (stream[i]) push(1'b0, stream[i], 64'hFFFF_FFFF_0000_0000 + 64'(i) * 64'd4, 1'b1);
    drain(1'b0);

    // Fill to DEPTH, then push+pop every cycle
    bus_a.i_decode_stage_ready = 1'b0;
    push(1'b0, 32'h00100093, 64'h2000, 1'b0);
    push(1'b0, 32'h00200113, 64'h2004, 1'b0);
    check("a_full_ready", bus_a.o_decode_stage_ready, 0);
    bus_a.i_decode_stage_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(1'b0, 32'h00300193 + (32'(k) << 20), 64'h2008 + 64'(k) * 64'd4, 1'b0);
      check("a_stream_ready", bus_a.o_decode_stage_ready, 1);
      check("a_stream_valid", bus_a.o_decode_stage_valid, 1);
    end
    drain(1'b0);

    // Flush with a same-cycle push (B, DEPTH=3 so the push would be accepted)
    bus_b.i_decode_stage_ready = 1'b0;
    push(1'b1, 32'h00150513, 64'h100, 1'b0);
    push(1'b1, 32'h00B50533, 64'h104, 1'b0);
    bus_b.i_decode_stage_flush = 1'b1;
    bus_b.i_decode_stage_instr = 32'h0000007F;
    bus_b.i_decode_stage_pc    = 32'h108;
    bus_b.i_decode_stage_valid = 1'b1;
    check("b_flush_ready", bus_b.o_decode_stage_ready, 1);
    @(posedge clk);
    #1;
    bus_b.i_decode_stage_flush = 1'b0;
    bus_b.i_decode_stage_valid = 1'b0;
    check("b_flush_valid", bus_b.o_decode_stage_valid, 0);
    check("b_flush_cnt", bus_b.o_decode_stage_illegal_cnt, 0);
    bus_b.i_decode_stage_ready = 1'b1;
    push(1'b1, 32'h00A52023, 64'h10C, 1'b0);
    check("b_after_flush_instr", bus_b.o_decode_stage_instr, 32'h00A52023);
    drain(1'b1);

    // ld on RV32 is illegal
    bus_b.i_decode_stage_ready = 1'b0;
    push(1'b1, 32'h0000B103, 64'h200, 1'b0);
    check("ld32_ill", bus_b.o_decode_stage_illegal, 1);
    check("ld32_ctrl", bus_b.o_decode_stage_ctrl, 0);
    drain(1'b1);
    @(posedge clk);
    #1;
    check("ld32_cnt", bus_b.o_decode_stage_illegal_cnt, 1);

    // RV32-only illegals, then saturate the 4-bit counter
    push(1'b1, 32'h0015051B, 64'h204, 1'b0);
    push(1'b1, 32'h00056003, 64'h208, 1'b0);
    push(1'b1, 32'h00A53023, 64'h20C, 1'b0);
    push(1'b1, 32'h00052003, 64'h210, 1'b0);
    for (int k = 0; k < 14; k++) push(1'b1, 32'h0000007F, 64'h300 + 64'(k) * 64'd4, 1'b0);
    drain(1'b1);
    @(posedge clk);
    #1;
    check("b_cnt_sat", bus_b.o_decode_stage_illegal_cnt, 4'hF);

    // Asynchronous reset with two entries buffered
    bus_a.i_decode_stage_ready = 1'b0;
    push(1'b0, 32'h00100093, 64'h3000, 1'b0);
    push(1'b0, 32'h0000007F, 64'h3004, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus_a.o_decode_stage_valid, 0);
    check("arst_ready", bus_a.o_decode_stage_ready, 0);
    check("arst_ctrl", bus_a.o_decode_stage_ctrl, 0);
    check("arst_instr", bus_a.o_decode_stage_instr, 0);
    check("arst_pc", bus_a.o_decode_stage_pc, 0);
    check("arst_cnt", bus_a.o_decode_stage_illegal_cnt, 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_ready_after", bus_a.o_decode_stage_ready, 1);
    check("arst_valid_after", bus_a.o_decode_stage_valid, 0);

    // Counting resumes after reset
    push(1'b0, 32'h0000007F, 64'h4000, 1'b0);
    drain(1'b0);
    @(posedge clk);
    #1;
    check("a_cnt_after_rst", bus_a.o_decode_stage_illegal_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
